// File: rtl/score_digit_renderer.sv
// score_digit_renderer
//   Five-digit decimal score overlay for the VGA pixel path.
//   A double-dabble converter turns the 16-bit binary score into BCD over
//   16 cycles. The result is copied into the displayed digits only at a
//   frame boundary, so a frame never shows two different scores. A
//   three-stage pixel pipeline addresses the shared digit glyph ROMs,
//   selects the returned word of the right digit and keys out the
//   transparent colour.
//
// Ports
//   Clk, Reset_n          clock (rising edge), synchronous active-low reset
//   score, score_load     binary score and its one-cycle load strobe
//   frame_start           one-cycle pulse at start of vertical blank
//   DrawX, DrawY          current pixel position
//   digit_rgb_flat        registered ROM words, digit d at [24d+23:24d]
//   rom_read_address      shared glyph address {row[4:0], col[4:0]}
//   pixel_rgb, pixel_on   overlay colour (0 when transparent) and opaque flag
//   busy                  BCD conversion in progress
//   bcd_display           digits on screen, [19:16] = ten-thousands
//
// Converter states
//   state | meaning
//   IDLE  | waiting for score_load
//   SHIFT | 16 add-3/shift steps in progress (busy)
//   DONE  | result just written to bcd_result, back to IDLE next cycle
module score_digit_renderer #(
    parameter logic [9:0]  X0          = 10'd480,
    parameter logic [9:0]  Y0          = 10'd8,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
    parameter bit          SUPPRESS_LZ = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [15:0]  score,
    input  logic         score_load,
    input  logic         frame_start,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    input  logic [239:0] digit_rgb_flat,
    output logic [9:0]   rom_read_address,
    output logic [23:0]  pixel_rgb,
    output logic         pixel_on,
    output logic         busy,
    output logic [19:0]  bcd_display
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    conv_state_t state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] result_q, result_d;
    logic [19:0] display_q, display_d;

    logic [9:0]  addr_q, addr_d;
    logic        inbox_a_q, inbox_a_d;
    logic [3:0]  digit_a_q, digit_a_d;
    logic        blank_a_q, blank_a_d;
    logic        inbox_b_q;
    logic [3:0]  digit_b_q;
    logic        blank_b_q;
    logic        pixel_on_q, pixel_on_d;
    logic [23:0] pixel_rgb_q, pixel_rgb_d;

    logic [19:0] adj;
    logic [35:0] shifted;

    // Double-dabble converter
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        adj      = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[18:0], bin_q, 1'b0};

        case (state_q)
            IDLE: ;
            SHIFT: begin
                bcd_d = shifted[35:16];
                bin_d = shifted[15:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d  = DONE;
                    result_d = shifted[35:16];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new load restarts from any state; the latest score wins.
        if (score_load) begin
            state_d = SHIFT;
            bin_d   = score;
            bcd_d   = '0;
            cnt_d   = '0;
        end

        // Latch uses the pre-edge result, so a simultaneous load in IDLE
        // shows the previous score this frame.
        display_d = display_q;
        if (frame_start && (state_q != SHIFT)) begin
            display_d = result_q;
        end
    end

    // Pixel stage A: box test, glyph address, digit and blanking
    logic       in_x, in_y;
    logic [9:0] relx, rely;
    logic [2:0] slot;
    logic [3:0] nib [5];
    logic [4:0] zero_prefix;
    logic       lz_blank;

    always_comb begin
        in_x = (DrawX >= X0) && ({1'b0, DrawX} < ({1'b0, X0} + 11'd160));
        in_y = (DrawY >= Y0) && ({1'b0, DrawY} < ({1'b0, Y0} + 11'd32));
        relx = DrawX - X0;
        rely = DrawY - Y0;
        slot = relx[7:5];

        for (int s = 0; s < 5; s++) begin
            nib[s] = display_q[19-4*s -: 4];
        end
        // zero_prefix[s]: every digit in slots 0..s is zero
        zero_prefix[0] = (nib[0] == 4'd0);
        for (int s = 1; s < 5; s++) begin
            zero_prefix[s] = zero_prefix[s-1] && (nib[s] == 4'd0);
        end

        digit_a_d = 4'hF;
        lz_blank  = 1'b0;
        case (slot)
            3'd0: begin digit_a_d = nib[0]; lz_blank = zero_prefix[0]; end
            3'd1: begin digit_a_d = nib[1]; lz_blank = zero_prefix[1]; end
            3'd2: begin digit_a_d = nib[2]; lz_blank = zero_prefix[2]; end
            3'd3: begin digit_a_d = nib[3]; lz_blank = zero_prefix[3]; end
            3'd4: begin digit_a_d = nib[4]; lz_blank = 1'b0; end
            default: ;
        endcase

        inbox_a_d = in_x && in_y;
        addr_d    = inbox_a_d ? {rely[4:0], relx[4:0]} : 10'd0;
        // Non-decimal nibbles cannot occur but are blanked rather than
        // indexing past the ten ROM words.
        blank_a_d = (SUPPRESS_LZ && lz_blank) || (digit_a_d > 4'd9);
    end

    // Pixel stage C: digit select and colour key
    logic [7:0]  sel_base;
    logic [23:0] sel;

    always_comb begin
        sel_base    = 8'(digit_b_q) * 8'd24;
        sel         = (digit_b_q <= 4'd9) ? digit_rgb_flat[sel_base +: 24] : KEY_COLOR;
        pixel_on_d  = inbox_b_q && !blank_b_q && (sel != KEY_COLOR);
        pixel_rgb_d = pixel_on_d ? sel : 24'd0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            display_q   <= '0;
            addr_q      <= '0;
            inbox_a_q   <= 1'b0;
            digit_a_q   <= '0;
            blank_a_q   <= 1'b0;
            inbox_b_q   <= 1'b0;
            digit_b_q   <= '0;
            blank_b_q   <= 1'b0;
            pixel_on_q  <= 1'b0;
            pixel_rgb_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            display_q   <= display_d;
            addr_q      <= addr_d;
            inbox_a_q   <= inbox_a_d;
            digit_a_q   <= digit_a_d;
            blank_a_q   <= blank_a_d;
            // Stage B lines the flags up with the ROM's registered data.
            inbox_b_q   <= inbox_a_q;
            digit_b_q   <= digit_a_q;
            blank_b_q   <= blank_a_q;
            pixel_on_q  <= pixel_on_d;
            pixel_rgb_q <= pixel_rgb_d;
        end
    end

    assign rom_read_address = addr_q;
    assign pixel_rgb        = pixel_rgb_q;
    assign pixel_on         = pixel_on_q;
    assign busy             = (state_q == SHIFT);
    assign bcd_display      = display_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
module tb_score_digit_renderer;

    localparam int X0 = 480;
    localparam int Y0 = 8;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [15:0]  score;
    logic         score_load;
    logic         frame_start;
    logic [9:0]   DrawX;
    logic [9:0]   DrawY;
    logic [239:0] digit_rgb_flat = '0;
    logic [9:0]   rom_read_address;
    logic [23:0]  pixel_rgb;
    logic         pixel_on;
    logic         busy;
    logic [19:0]  bcd_display;

    score_digit_renderer dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .score            (score),
        .score_load       (score_load),
        .frame_start      (frame_start),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .digit_rgb_flat   (digit_rgb_flat),
        .rom_read_address (rom_read_address),
        .pixel_rgb        (pixel_rgb),
        .pixel_on         (pixel_on),
        .busy             (busy),
        .bcd_display      (bcd_display)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last completed conversion, displayed value, pending load
    int result_val = 0;
    int disp_val   = 0;
    int pending    = 0;

    int px[$];
    int py[$];

    // Glyph content: a few key-colour and pure-green words, the rest
    // encode digit and address so a wrong digit or address shows up.
    function automatic logic [23:0] rom_f(input int d, input logic [9:0] a);
        if (a[3:0] == 4'hF) return 24'hFF00FF;
        if (a[3:0] == 4'hE) return 24'h00FF00;
        return {4'(d), a, 10'(a * 7 + d * 3)};
    endfunction

    always @(posedge Clk) begin
        for (int d = 0; d < 10; d++) begin
            digit_rgb_flat[24*d +: 24] <= rom_f(d, rom_read_address);
        end
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void exp_pix(input int x, input int y, input int disp,
                                    output logic [9:0] addr, output logic on,
                                    output logic [23:0] rgb);
        int p10 [5] = '{10000, 1000, 100, 10, 1};
        int relx, rely, s, dig;
        bit inbox, blank;
        logic [23:0] w;
        relx  = x - X0;
        rely  = y - Y0;
        inbox = (x >= X0) && (x < X0 + 160) && (y >= Y0) && (y < Y0 + 32);
        addr  = 10'd0;
        on    = 1'b0;
        rgb   = 24'd0;
        if (inbox) begin
            addr  = 10'(rely * 32 + relx % 32);
            s     = relx / 32;
            dig   = (disp / p10[s]) % 10;
            blank = (s < 4) && (disp < p10[s]);
            w     = rom_f(dig, addr);
            on    = !blank && (w != 24'hFF00FF);
            rgb   = on ? w : 24'd0;
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load(input int v);
        score      = 16'(v);
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        pending    = v;
    endtask

    // Counts busy samples from now until it drops; bounded.
    task automatic wait_busy(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (busy === 1'b1 && c < 40) begin
            c++;
            step();
        end
        check_eq(tag, c, exp_cycles);
        result_val = pending;
    endtask

    task automatic frame_pulse(input bit idle);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (idle) disp_val = result_val;
        check_eq("bcd_display", bcd_display, to_bcd(disp_val));
    endtask

    task automatic run_pixels();
        int n;
        logic [9:0]  ea;
        logic        eo;
        logic [23:0] er;
        n = px.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                DrawX = 10'(px[i]);
                DrawY = 10'(py[i]);
            end else begin
                DrawX = 10'd0;
                DrawY = 10'd0;
            end
            step();
            if (i < n) begin
                exp_pix(px[i], py[i], disp_val, ea, eo, er);
                check_eq("rom_addr", rom_read_address, ea);
            end
            if (i >= 2) begin
                exp_pix(px[i-2], py[i-2], disp_val, ea, eo, er);
                check_eq("pixel_on", pixel_on, eo);
                check_eq("pixel_rgb", pixel_rgb, er);
            end
        end
        px.delete();
        py.delete();
    endtask

    task automatic add_px(input int x, input int y);
        px.push_back(x);
        py.push_back(y);
    endtask

    initial begin
        Reset_n     = 1'b0;
        score       = '0;
        score_load  = 1'b0;
        frame_start = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        step(); step(); step();
        Reset_n = 1'b1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bcd", bcd_display, 0);
        check_eq("rst_addr", rom_read_address, 0);
        check_eq("rst_on", pixel_on, 0);
        check_eq("rst_rgb", pixel_rgb, 0);

        // Basic conversion and frame latch
        start_load(12345);
        wait_busy("busy_12345", 16);
        frame_pulse(1);

        // frame_start while busy leaves the display alone
        start_load(65535);
        frame_pulse(0);
        wait_busy("busy_65535", 15);
        frame_pulse(1);

        // 00042: leading-zero blanking, digit selection and box edges
        start_load(42);
        wait_busy("busy_42", 16);
        frame_pulse(1);
        for (int x = X0; x < X0 + 160; x++) add_px(x, Y0);
        run_pixels();
        add_px(X0 + 159, Y0 + 31);
        add_px(X0 + 160, Y0);
        add_px(X0, Y0 + 32);
        add_px(X0 - 1, Y0);
        add_px(X0 + 128 + 14, Y0 + 3);
        add_px(X0 + 128 + 15, Y0 + 3);
        add_px(X0 + 96 + 14, Y0 + 31);
        add_px(X0, Y0 - 1);
        run_pixels();

        // Reset part-way through a conversion
        start_load(23456);
        for (int i = 0; i < 6; i++) step();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        result_val = 0;
        disp_val   = 0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_bcd", bcd_display, 0);
        check_eq("mid_rst_addr", rom_read_address, 0);
        check_eq("mid_rst_on", pixel_on, 0);
        check_eq("mid_rst_rgb", pixel_rgb, 0);
        frame_pulse(1);

        // Reload mid-shift: latest score wins, busy restarts
        start_load(54321);
        for (int i = 0; i < 4; i++) step();
        start_load(99);
        wait_busy("busy_reload", 16);
        frame_pulse(1);

        // Zero score: single "0" in the rightmost slot
        start_load(0);
        wait_busy("busy_0", 16);
        frame_pulse(1);
        for (int x = X0; x < X0 + 160; x += 3) add_px(x, Y0 + 5);
        run_pixels();

        // Simultaneous frame_start and score_load from IDLE
        start_load(99);
        wait_busy("busy_99b", 16);
        score       = 16'd777;
        score_load  = 1'b1;
        frame_start = 1'b1;
        step();
        score_load  = 1'b0;
        frame_start = 1'b0;
        pending     = 777;
        disp_val    = 99;
        check_eq("simul_bcd", bcd_display, to_bcd(disp_val));
        check_eq("simul_busy", busy, 1);
        wait_busy("busy_777", 16);
        frame_pulse(1);

        // Randomized scores and pixels
        for (int k = 0; k < 14; k++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            case (k % 4)
                0: v = v % 10;
                1: v = v % 1000;
                default: ;
            endcase
            start_load(v);
            wait_busy("busy_rand", 16);
            frame_pulse(1);
            for (int j = 0; j < 30; j++) begin
                add_px(X0 - 10 + int'($urandom_range(0, 180)), int'($urandom_range(0, 45)));
            end
            run_pixels();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_digit_renderer.md
Name: score_digit_renderer

Overview:
- Draws a 5-digit decimal score overlay for the VGA pixel path, directly upstream of the 32x32 digit glyph ROMs (Zero..Nine) and downstream of them for colour selection.
- Converts a 16-bit binary score to BCD sequentially and latches the result into the display at frame boundaries so digits never tear mid-frame.
- For each DrawX/DrawY it drives the shared glyph read address, selects the returned 24-bit pixel of the correct digit and emits colour plus an opaque flag to the colour mapper.

Parameters:
- X0, 10'd480, left pixel column of the score box
- Y0, 10'd8, top pixel row of the score box
- KEY_COLOR, 24'hFF00FF, ROM colour treated as transparent
- SUPPRESS_LZ, 1, 1 = blank leading zeros (rightmost digit always shown)

Ports:
- Clk  in  1  pixel/system clock, all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- score  in  16  binary score value
- score_load  in  1  one-cycle pulse: sample score, start conversion
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- digit_rgb_flat  in  240  ROM outputs, digit d at bits [24d+23:24d]
- rom_read_address  out  10  shared read address to all ten digit ROMs
- pixel_rgb  out  24  overlay colour, 0 when not opaque
- pixel_on  out  1  overlay pixel opaque
- busy  out  1  BCD conversion in progress
- bcd_display  out  20  digits currently displayed, [19:16] = ten-thousands

Behaviour:
- Reset (Reset_n low at an edge): rom_read_address=0, pixel_rgb=0, pixel_on=0, busy=0, bcd_display=0, converter in IDLE, pipeline flags cleared. Reset overrides everything incl. mid-conversion.
- Converter FSM IDLE/SHIFT/DONE, double-dabble on 16-bit shift reg + 20-bit BCD reg:
  - IDLE: score_load -> load score, clear BCD, cnt=0, go SHIFT; busy=1 from next edge.
  - SHIFT: each cycle add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1; cnt++; after 16th shift go DONE. busy high exactly 16 cycles.
  - DONE: result held in bcd_result, busy=0, return to IDLE next cycle.
  - score_load while SHIFT/DONE: restart with new score (latest wins), cnt=0, busy stays high.
- Display latch: on frame_start with busy=0, bcd_display <= bcd_result (if no conversion since reset, keeps 0). frame_start while busy=1: bcd_display unchanged. Simultaneous frame_start and score_load in IDLE: latch old result, start new conversion.
- Pixel pipeline (stage A at edge N samples DrawX/DrawY):
  - relx = DrawX - X0, rely = DrawY - Y0 (10-bit; in-box iff DrawX>=X0, DrawX<X0+160, DrawY>=Y0, DrawY<Y0+32).
  - Edge N: rom_read_address <= {rely[4:0], relx[4:0]} (0 when outside box); register inbox_a, slot_a = relx[7:5] (0..4, slot 0 = ten-thousands), digit_a = bcd_display nibble of slot_a, blank_a = leading-zero blank.
  - Edge N+1: ROMs register data; stage B shifts inbox/digit/blank flags.
  - Edge N+2: sel = digit_rgb_flat[digit]; pixel_on <= inbox & ~blank & (sel != KEY_COLOR); pixel_rgb <= pixel_on ? sel : 0.
  - Total latency DrawX/DrawY -> pixel_rgb/pixel_on = 3 edges (N..N+2); fully pipelined, one pixel per clock.
- Leading-zero blanking (SUPPRESS_LZ=1): slot s blanked iff all digits in slots 0..s are 0 and s<4. Score 0 shows single "0" in slot 4.
- Digit nibble >9 impossible by construction; if seen, treat as blank.
- bcd_display changes take effect for pixels sampled after the latch edge; no mid-pixel glitch.

Test Plan:
- Reset, score=12345, score_load pulse -> busy high 16 cycles, then frame_start -> bcd_display=20'h12345.
- score=65535 load, frame_start during busy -> bcd_display holds previous 20'h12345; next frame_start after done -> 20'h65535.
- bcd_display=20'h00042, DrawX=X0+0..X0+95, DrawY=Y0 -> pixel_on=0 in slots 0-2; DrawX=X0+96 -> rom_read_address=10'd0, 3 edges later pixel_rgb = digit 4 ROM word 0 (if not KEY_COLOR).
- Box edges: DrawX=X0+159, DrawY=Y0+31 -> address 10'h3FF, in-box; DrawX=X0+160 or DrawY=Y0+32 or DrawX=X0-1 -> pixel_on=0, pixel_rgb=0.
- ROM word equal to 24'hFF00FF in-box -> pixel_on=0, pixel_rgb=0; word 24'h00FF00 -> pixel_on=1, pixel_rgb=24'h00FF00.
- score_load at shift 7, then Reset_n low 1 cycle -> busy=0, bcd_display=0, outputs 0; second load mid-SHIFT with 00099 -> busy 16 cycles from second load, result 20'h00099.
